// File: rtl/env_pkg.sv
// Shared definitions for the envelope generator: state codes, default widths
// and the width of the rate fields.
package env_pkg;

    localparam int DEF_O  = 16;
    localparam int DEF_EW = 8;
    localparam int RATE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_e;

endpackage

// File: rtl/env_scale.sv
// Two-stage unsigned scaler: sample_out = (sample * level) >> EW, truncated.
// Valid travels alongside the data; sample_out holds between valid samples.
module env_scale
    import env_pkg::*;
#(
    parameter int O  = DEF_O,
    parameter int EW = DEF_EW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [O-1:0]  sample_in,
    input  logic          sample_valid,
    input  logic [EW-1:0] level,
    output logic [O-1:0]  sample_out,
    output logic          sample_out_valid
);

    logic [O-1:0]  smp_p0;
    logic [EW-1:0] lvl_p0;
    logic          vld_p0;

    function automatic logic [O-1:0] scale_trunc(input logic [O-1:0] s, input logic [EW-1:0] l);
        logic [O+EW-1:0] prod;
        prod = (O+EW)'(s) * (O+EW)'(l);
        return prod[O+EW-1:EW];
    endfunction

    // stage p0: capture sample and the level in force on the cycle it arrived
    always_ff @(posedge clk) begin
        if (sample_valid) begin
            smp_p0 <= sample_in;
            lvl_p0 <= level;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= sample_valid;
        end
    end

    // stage p1: product, truncated back to sample width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
        end else begin
            sample_out_valid <= vld_p0;
            if (vld_p0) begin
                sample_out <= scale_trunc(smp_p0, lvl_p0);
            end
        end
    end

endmodule

// File: rtl/env_gen.sv
// ADSR envelope generator: gate-edge driven FSM stepping the level on tick,
// with the level applied to the incoming sample stream by env_scale.
module env_gen
    import env_pkg::*;
#(
    parameter int O  = DEF_O,
    parameter int EW = DEF_EW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gate,
    input  logic              tick,
    input  logic [RATE_W-1:0] attack_rate,
    input  logic [RATE_W-1:0] decay_rate,
    input  logic [EW-1:0]     sustain_lvl,
    input  logic [RATE_W-1:0] release_rate,
    input  logic [O-1:0]      sample_in,
    input  logic              sample_valid,
    output logic [O-1:0]      sample_out,
    output logic              sample_out_valid,
    output logic [EW-1:0]     env_level,
    output logic [2:0]        env_state
);

    // one extra bit so sums and floors never wrap
    localparam int SW = EW + 1;
    localparam logic [SW-1:0] LVL_MAX = SW'((1 << EW) - 1);

    env_state_e    state_q, state_d;
    logic [EW-1:0] level_q, level_d;
    logic          gate_q;
    logic          rise, fall, step_en;
    logic [SW-1:0] atk_sum, dec_floor, rel_step, dec_step;

    function automatic logic [SW-1:0] rate_step(input logic [RATE_W-1:0] r);
        return SW'(r) + SW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            level_q <= '0;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            gate_q  <= gate;
        end
    end

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        rise      = gate & ~gate_q;
        fall      = ~gate & gate_q;
        step_en   = tick & ~(rise | fall);
        atk_sum   = {1'b0, level_q} + rate_step(attack_rate);
        dec_step  = rate_step(decay_rate);
        dec_floor = {1'b0, sustain_lvl} + dec_step;
        rel_step  = rate_step(release_rate);

        case (state_q)
            ST_IDLE: begin
                level_d = '0;
                if (rise) state_d = ST_ATTACK;
            end
            ST_ATTACK: begin
                if (fall) begin
                    state_d = ST_RELEASE;
                end else if (step_en) begin
                    if (atk_sum >= LVL_MAX) begin
                        level_d = LVL_MAX[EW-1:0];
                        state_d = ST_DECAY;
                    end else begin
                        level_d = atk_sum[EW-1:0];
                    end
                end
            end
            ST_DECAY: begin
                if (fall) begin
                    state_d = ST_RELEASE;
                end else if (step_en) begin
                    if ({1'b0, level_q} <= dec_floor) begin
                        level_d = sustain_lvl;
                        state_d = ST_SUSTAIN;
                    end else begin
                        level_d = level_q - dec_step[EW-1:0];
                    end
                end
            end
            ST_SUSTAIN: begin
                if (fall) begin
                    state_d = ST_RELEASE;
                end else if (step_en) begin
                    level_d = sustain_lvl;
                end
            end
            ST_RELEASE: begin
                // retrigger keeps the current level so attack resumes from it
                if (rise) begin
                    state_d = ST_ATTACK;
                end else if (step_en) begin
                    if ({1'b0, level_q} <= rel_step) begin
                        level_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        level_d = level_q - rel_step[EW-1:0];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                level_d = '0;
            end
        endcase
    end

    assign env_state = state_q;
    assign env_level = level_q;

    env_scale #(
        .O  (O),
        .EW (EW)
    ) u_scale (
        .clk              (clk),
        .rst_n            (rst_n),
        .sample_in        (sample_in),
        .sample_valid     (sample_valid),
        .level            (level_q),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid)
    );

endmodule
